// File: rtl/core_pkg.sv
// Shared RV32I core definitions: writeback source and load funct3 encodings,
// plus default datapath widths.
package core_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_ZERO = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'd0,
    F3_LH  = 3'd1,
    F3_LW  = 3'd2,
    F3_LBU = 3'd4,
    F3_LHU = 3'd5
  } load_f3_e;

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects the addressed byte/halfword from an
// aligned memory word and sign- or zero-extends it according to funct3.
module load_align #(
  parameter int XLEN = core_pkg::DEF_XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);
  import core_pkg::*;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Halfword lane uses only off[1]; a misaligned off[0] is silently ignored.
  assign lane_b = word[{off, 3'b000} +: 8];
  assign lane_h = word[{off[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, lane_b};
      F3_LH:   data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback formatter and WB-to-ID read bypass.
// Optional build macro WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module wb_stage #(
  parameter int XLEN   = core_pkg::DEF_XLEN,
  parameter int REG_AW = core_pkg::DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_wen,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_wb_sel,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_pc_plus4,
  input  logic [XLEN-1:0]   in_load_word,
  input  logic [2:0]        in_funct3,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_data,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [XLEN-1:0]   id_op1_rf,
  input  logic [XLEN-1:0]   id_op2_rf,
  output logic [XLEN-1:0]   id_op1,
  output logic [XLEN-1:0]   id_op2
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]       instret
`endif
);
  import core_pkg::*;

  logic [XLEN-1:0]   load_fmt;
  logic [XLEN-1:0]   wb_data;
  logic              valid_q;
  logic              reg_wen_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   data_q;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3 (in_funct3),
    .off    (in_alu_result[1:0]),
    .word   (in_load_word),
    .data   (load_fmt)
  );

  always_comb begin
    wb_data = '0;
    case (in_wb_sel)
      WB_ALU:  wb_data = in_alu_result;
      WB_LOAD: wb_data = load_fmt;
      WB_PC4:  wb_data = in_pc_plus4;
      default: wb_data = '0;
    endcase
  end

  // Flush kills the control bits only; rd/data are don't-care once valid drops.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      reg_wen_q <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      reg_wen_q <= 1'b0;
      rd_q      <= in_rd;
      data_q    <= wb_data;
    end else if (!stall) begin
      valid_q   <= in_valid;
      reg_wen_q <= in_reg_wen;
      rd_q      <= in_rd;
      data_q    <= wb_data;
    end
  end

  assign rf_wen  = valid_q & reg_wen_q & (rd_q != '0);
  assign rf_rd   = rd_q;
  assign rf_data = data_q;

  // rf_wen already excludes x0, so a zero read index can never match here.
  assign id_op1 = (rf_wen && (id_rs1 == rd_q)) ? data_q : id_op1_rf;
  assign id_op2 = (rf_wen && (id_rs2 == rd_q)) ? data_q : id_op2_rf;

`ifdef WB_INSTRET_EN
  // An instruction retires on the edge where it leaves the stage unstalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
    end else if (valid_q && !stall) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule
